// File: rtl/pc_branch_unit.sv
// Program counter with conditional branch and flush control.
// Also owns the output-pin source select toggle.
module pc_branch_unit #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic       bcf,
    input  logic       bbf,
    input  logic       buc,
    input  logic       toggleOut,
    input  logic       carry,
    input  logic       borrow,
    input  logic [7:0] r3,
    output logic [7:0] pc,
    output logic       flush,
    output logic       branch_taken,
    output logic       out_sel,
    output logic [7:0] pins_out
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t     state;
    state_t     stateNext;
    logic [7:0] pcNext;
    logic       outSelNext;
    logic       takenNext;
    logic       retire;
    logic       branchReq;

    // A request only counts when running and the instruction retires.
    // Every branch type adds the same offset, so the buc > bcf > bbf
    // priority cannot change the result; only the toggle is outranked.
    always_comb begin
        retire    = (state == RUN) && instr_valid;
        branchReq = buc | (bcf & carry) | (bbf & borrow);
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pc           <= PC_RESET;
            out_sel      <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            state        <= stateNext;
            pc           <= pcNext;
            out_sel      <= outSelNext;
            branch_taken <= takenNext;
        end
    end

    // Next-state and next-datapath values.
    always_comb begin
        stateNext  = RUN;
        pcNext     = pc;
        outSelNext = out_sel;
        takenNext  = 1'b0;
        unique case (state)
            RUN: begin
                if (retire) begin
                    if (branchReq) begin
                        pcNext    = pc + r3;
                        stateNext = FLUSH;
                        takenNext = 1'b1;
                    end else begin
                        pcNext = pc + 8'd1;
                        if (toggleOut) begin
                            outSelNext = ~out_sel;
                        end
                    end
                end
            end
            FLUSH: begin
                stateNext = RUN;
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        flush    = (state == FLUSH);
        pins_out = out_sel ? pc : r3;
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed testbench for pc_branch_unit.
// Vectors carry hand-computed expected values.
module tb_pc_branch_unit;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       bcf;
    logic       bbf;
    logic       buc;
    logic       toggleOut;
    logic       carry;
    logic       borrow;
    logic [7:0] r3;
    logic [7:0] pc;
    logic       flush;
    logic       branch_taken;
    logic       out_sel;
    logic [7:0] pins_out;

    int checks = 0;
    int failures = 0;

    pc_branch_unit #(
        .PC_RESET(8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .bcf         (bcf),
        .bbf         (bbf),
        .buc         (buc),
        .toggleOut   (toggleOut),
        .carry       (carry),
        .borrow      (borrow),
        .r3          (r3),
        .pc          (pc),
        .flush       (flush),
        .branch_taken(branch_taken),
        .out_sel     (out_sel),
        .pins_out    (pins_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic iv,
                         input logic u,
                         input logic c,
                         input logic b,
                         input logic t,
                         input logic cy,
                         input logic bw,
                         input logic [7:0] off);
        instr_valid = iv;
        buc         = u;
        bcf         = c;
        bbf         = b;
        toggleOut   = t;
        carry       = cy;
        borrow      = bw;
        r3          = off;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string tag,
                           input logic [7:0] ePc,
                           input logic eFl,
                           input logic eBt,
                           input logic eOs);
        check({tag, ".pc"}, pc, ePc);
        check({tag, ".flush"}, {7'd0, flush}, {7'd0, eFl});
        check({tag, ".bt"}, {7'd0, branch_taken}, {7'd0, eBt});
        check({tag, ".osel"}, {7'd0, out_sel}, {7'd0, eOs});
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 1, 0, 0, 1, 0, 0, 8'h33);
        step();
        expect4("rst", 8'h00, 0, 0, 0);
        step();
        expect4("rst_hold", 8'h00, 0, 0, 0);

        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 8'h00);
        step();
        expect4("inc1", 8'h01, 0, 0, 0);
        step();
        expect4("inc2", 8'h02, 0, 0, 0);
        step();
        expect4("inc3", 8'h03, 0, 0, 0);

        drive(1, 1, 0, 0, 0, 0, 0, 8'h0D);
        step();
        expect4("br_to10", 8'h10, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
        step();
        expect4("fl_end10", 8'h10, 0, 0, 0);

        drive(1, 1, 0, 0, 0, 0, 0, 8'h05);
        step();
        expect4("buc05", 8'h15, 1, 1, 0);
        step();
        expect4("fl_ignore", 8'h15, 0, 0, 0);

        drive(1, 1, 0, 0, 0, 0, 0, 8'h0B);
        step();
        expect4("br_to20", 8'h20, 1, 1, 0);
        drive(0, 1, 0, 0, 1, 0, 0, 8'h00);
        step();
        expect4("fl_end20", 8'h20, 0, 0, 0);
        step();
        expect4("iv0_hold", 8'h20, 0, 0, 0);

        drive(1, 0, 1, 0, 0, 0, 1, 8'h55);
        step();
        expect4("bcf_nc", 8'h21, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 1, 8'hF0);
        step();
        expect4("bbf_wrap", 8'h11, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
        step();

        drive(1, 1, 0, 0, 0, 0, 0, 8'h2F);
        step();
        expect4("br_to40", 8'h40, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
        step();

        drive(1, 0, 0, 0, 1, 0, 0, 8'hAA);
        #1;
        check("pins0", pins_out, 8'hAA);
        step();
        expect4("tog1", 8'h41, 0, 0, 1);
        check("pins1", pins_out, 8'h41);
        step();
        expect4("tog2", 8'h42, 0, 0, 0);
        check("pins2", pins_out, 8'hAA);

        drive(1, 1, 0, 0, 1, 0, 0, 8'h03);
        step();
        expect4("buc_tog", 8'h45, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
        step();

        drive(1, 1, 0, 0, 0, 0, 0, 8'h00);
        step();
        expect4("r3_zero", 8'h45, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
        step();
        expect4("r3z_end", 8'h45, 0, 0, 0);

        drive(1, 0, 0, 0, 1, 0, 0, 8'h00);
        step();
        expect4("tog3", 8'h46, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 0, 0, 8'h38);
        step();
        expect4("br_to7e", 8'h7E, 1, 1, 1);
        rst = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 0, 8'h11);
        step();
        expect4("rst_fl", 8'h00, 0, 0, 0);

        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 0, 8'hFF);
        step();
        expect4("br_toff", 8'hFF, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
        step();
        drive(1, 0, 1, 1, 0, 0, 0, 8'h07);
        step();
        expect4("ff_wrap", 8'h00, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The block SHALL have the parameter PC_RESET, default 8'h00, giving the program counter value loaded on reset.
REQ-002 The block SHALL have the port clk  input  1  the single clock; every register updates on the rising edge.
REQ-003 The block SHALL have the port rst  input  1  reset; synchronous, active-high.
REQ-004 The block SHALL have the port instr_valid  input  1  the current decode outputs are valid and the instruction retires this cycle.
REQ-005 The block SHALL have the port bcf  input  1  branch-on-carry request from the mov/branch decoder.
REQ-006 The block SHALL have the port bbf  input  1  branch-on-borrow request from the mov/branch decoder.
REQ-007 The block SHALL have the port buc  input  1  unconditional branch request from the mov/branch decoder.
REQ-008 The block SHALL have the port toggleOut  input  1  output-source toggle request from the mov/branch decoder.
REQ-009 The block SHALL have the port carry  input  1  ALU carry flag.
REQ-010 The block SHALL have the port borrow  input  1  ALU borrow flag.
REQ-011 The block SHALL have the port r3  input  8  current r3 value, used as the branch offset and the output-pin source.
REQ-012 The block SHALL have the port pc  output  8  program counter (registered).
REQ-013 The block SHALL have the port flush  output  1  high while the in-flight fetched instruction is discarded (registered).
REQ-014 The block SHALL have the port branch_taken  output  1  one-cycle pulse after a taken branch (registered).
REQ-015 The block SHALL have the port out_sel  output  1  output-pin source select: 0 selects r3, 1 selects pc (registered).
REQ-016 The block SHALL have the port pins_out  output  8  combinational mux, out_sel ? pc : r3.

Function
REQ-017 The block SHALL implement a two-state FSM, RUN and FLUSH; flush SHALL be 1 exactly when the state is FLUSH.
REQ-018 In RUN, a branch SHALL be taken when instr_valid=1 and (buc | (bcf & carry) | (bbf & borrow)).
REQ-019 On a taken branch, the next-cycle values SHALL be pc <= pc + r3 (modulo 256, r3 unsigned, wrap with no error), state <= FLUSH, and branch_taken <= 1.
REQ-020 In RUN with instr_valid=1 and no taken branch, pc SHALL update as pc <= pc + 1 modulo 256 (so 8'hFF wraps to 8'h00).
REQ-021 In RUN with instr_valid=1 and toggleOut=1, out_sel SHALL invert and pc SHALL increment by 1.
REQ-022 In RUN with instr_valid=0, pc, out_sel and state SHALL hold, and branch_taken SHALL be 0.
REQ-023 In FLUSH, all decode inputs and instr_valid SHALL be ignored; pc and out_sel SHALL hold; the next state SHALL be RUN; branch_taken SHALL be 0.
REQ-024 A bcf or bbf request with its flag low SHALL be treated as not taken, so pc increments by 1.
REQ-025 When several requests are asserted simultaneously, priority SHALL be buc > bcf > bbf > toggleOut, and a taken branch SHALL suppress the toggle.
REQ-026 A branch with r3=0 SHALL still count as taken: pc is unchanged, a FLUSH cycle follows, and branch_taken pulses.
REQ-027 branch_taken SHALL be high for exactly the one cycle in which flush first rises.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set pc=PC_RESET, state=RUN, flush=0, branch_taken=0 and out_sel=0, overriding all other inputs.
REQ-029 A reset asserted during FLUSH SHALL abort the flush, and the block SHALL be in RUN on the next cycle.
REQ-030 With rst held high, the outputs SHALL stay at their reset values.

Verification
REQ-031 Reset, then 3 cycles of instr_valid=1 with no requests -> pc = 00, 01, 02, 03; flush=0.
REQ-032 pc=10, buc=1, r3=8'h05 -> next cycle pc=15, flush=1, branch_taken=1; the following cycle flush=0 and pc=15 holds.
REQ-033 pc=20, bcf=1, carry=0 -> pc=21, no flush; then bbf=1, borrow=1, r3=8'hF0 -> pc=8'h11 (wrap-around).
REQ-034 toggleOut=1 twice, with r3=8'hAA and pc=40 -> pins_out: AA, then 41, then AA again; out_sel: 0, 1, 0.
REQ-035 buc=1 and toggleOut=1 together -> branch taken and out_sel unchanged; inputs during FLUSH (buc=1) produce no second branch.
REQ-036 rst=1 asserted during FLUSH with pc=8'h7E -> next cycle pc=00, flush=0, out_sel=0.
